// File: rtl/wfifo_pattern_gen.sv
// Frame-data source for the SDRAM write FIFO (write-clock domain).
// Patterns: increment, decrement, 16-bit Galois LFSR, constant.
// Backpressure comes from wfifo_full. Optional inter-frame gap.
// Outputs frame markers and a count of completed frames.
// Optional feature macro: PATGEN_CHECKSUM_EN adds frame_sum, the 32-bit sum
// of the words of the last completed frame.
`timescale 1ns/1ps
module wfifo_pattern_gen #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAME_LEN  = 480000,
  parameter int unsigned LEN_W      = 19,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [31:0] CONST_VAL  = 32'h0000_5A5A,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic              wfifo_wr_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              wfifo_full,
  output logic              wfifo_wr_en,
  output logic [DATA_W-1:0] wfifo_wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
`ifdef PATGEN_CHECKSUM_EN
  output logic [31:0]       frame_sum,
`endif
  output logic              busy
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // FRAME_END takes no cycle: its decision is folded into the edge leaving RUN/GAP.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] data_d, next_word;
  logic [15:0]       lfsr_q, lfsr_d, lfsr_nxt;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        mode_q, mode_d;
  logic [FCNT_W-1:0] cnt_d;
  logic              done_d, accept, last, frame_end, restart;

  function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m);
    logic [DATA_W-1:0] w;
    case (m)
      2'd0:    w = '0;
      2'd1:    w = '1;
      2'd2:    w = DATA_W'(LFSR_SEED);
      default: w = DATA_W'(CONST_VAL);
    endcase
    return w;
  endfunction

  // Write handshake and status flags
  assign wfifo_wr_en = (state_q == S_RUN) & ~wfifo_full;
  assign accept      = wfifo_wr_en;
  assign last        = (index_q == LAST_IDX);
  assign frame_start = (index_q == '0) & wfifo_wr_en;
  assign busy        = (state_q != S_IDLE);

  // Successor of the current word under the latched mode
  always_comb begin
    lfsr_nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    next_word = wfifo_wr_data;
    case (mode_q)
      2'd0:    next_word = wfifo_wr_data + DATA_W'(1);
      2'd1:    next_word = wfifo_wr_data - DATA_W'(1);
      2'd2:    next_word = DATA_W'(lfsr_nxt);
      default: next_word = wfifo_wr_data;
    endcase
  end

  // Next-state and datapath decisions
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    data_d    = wfifo_wr_data;
    lfsr_d    = lfsr_q;
    gap_d     = gap_q;
    mode_d    = mode_q;
    cnt_d     = frame_cnt;
    done_d    = 1'b0;
    frame_end = 1'b0;
    restart   = 1'b0;
    case (state_q)
      S_IDLE: if (enable) restart = 1'b1;
      S_RUN: begin
        if (accept) begin
          if (last) begin
            index_d = '0;
            done_d  = 1'b1;
            cnt_d   = frame_cnt + FCNT_W'(1);
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            index_d = index_q + LEN_W'(1);
            lfsr_d  = lfsr_nxt;
            data_d  = next_word;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) frame_end = 1'b1;
        else                   gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_end) begin
      if (enable) restart = 1'b1;
      else        state_d = S_IDLE;
    end
    if (restart) begin
      state_d = S_RUN;
      mode_d  = mode;
      index_d = '0;
      lfsr_d  = LFSR_SEED;
      data_d  = first_word(mode);
    end
  end

  // State and datapath registers
  always_ff @(posedge wfifo_wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      wfifo_wr_data <= '0;
      lfsr_q        <= LFSR_SEED;
      gap_q         <= '0;
      mode_q        <= 2'd0;
      frame_cnt     <= '0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      wfifo_wr_data <= data_d;
      lfsr_q        <= lfsr_d;
      gap_q         <= gap_d;
      mode_q        <= mode_d;
      frame_cnt     <= cnt_d;
      frame_done    <= done_d;
    end
  end

`ifdef PATGEN_CHECKSUM_EN
  logic [31:0] run_sum_q, sum_with_word;

  // Accumulator restarts on the first word of a frame
  always_comb begin
    sum_with_word = ((index_q == '0) ? 32'h0 : run_sum_q) + 32'(wfifo_wr_data);
  end

  // Running sum and latched per-frame sum
  always_ff @(posedge wfifo_wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sum_q <= 32'h0;
      frame_sum <= 32'h0;
    end else if (accept) begin
      run_sum_q <= sum_with_word;
      if (last) frame_sum <= sum_with_word;
    end
  end
`endif

endmodule

// File: tb/tb_wfifo_pattern_gen.sv
// Self-checking bench for wfifo_pattern_gen: behavioural frame model with
// per-cycle comparison, directed literal checks, and a small GAP_CYCLES=0 unit.
`timescale 1ns/1ps
module tb_wfifo_pattern_gen;
  localparam int unsigned DW = 16;
  localparam int unsigned FL = 8;
  localparam int unsigned GC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, enable = 1'b0, full = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        wr_en, fs, fd, busy;
  logic [15:0] data, fcnt;
`ifdef PATGEN_CHECKSUM_EN
  logic [31:0] fsum, fsum_b;
`endif

  logic        rstb_n = 1'b0, enb = 1'b0;
  logic        wr_en_b, fs_b, fd_b, busy_b;
  logic [3:0]  data_b;
  logic [7:0]  fcnt_b;

  wfifo_pattern_gen #(.DATA_W(DW), .FRAME_LEN(FL), .LEN_W(3), .GAP_CYCLES(GC),
                      .FCNT_W(16)) u_dut (
    .wfifo_wr_clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .wfifo_full(full), .wfifo_wr_en(wr_en), .wfifo_wr_data(data),
    .frame_start(fs), .frame_done(fd), .frame_cnt(fcnt),
`ifdef PATGEN_CHECKSUM_EN
    .frame_sum(fsum),
`endif
    .busy(busy));

  wfifo_pattern_gen #(.DATA_W(4), .FRAME_LEN(20), .LEN_W(5), .GAP_CYCLES(0),
                      .FCNT_W(8)) u_b (
    .wfifo_wr_clk(clk), .rst_n(rstb_n), .enable(enb), .mode(2'd0),
    .wfifo_full(1'b0), .wfifo_wr_en(wr_en_b), .wfifo_wr_data(data_b),
    .frame_start(fs_b), .frame_done(fd_b), .frame_cnt(fcnt_b),
`ifdef PATGEN_CHECKSUM_EN
    .frame_sum(fsum_b),
`endif
    .busy(busy_b));

  int checks = 0, passed = 0, cyc = 0;

  // Behavioural model: frame position, pending gap cycles, latched mode
  bit          m_busy, m_done;
  int          m_pos, m_gap;
  logic [1:0]  m_mode;
  int unsigned m_cnt;
  logic [31:0] m_sum, m_fsum;

  logic [15:0] acc_q[$];
  int          acc_cyc[$];
  bit          b_on = 1'b0;
  int          b_k = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Word at position p of a frame in mode md, straight from the pattern rules
  function automatic logic [15:0] word_at(logic [1:0] md, int p);
    logic [15:0] s;
    s = 16'h0;
    case (md)
      2'd0: s = 16'(p);
      2'd1: s = 16'hFFFF - 16'(p);
      2'd2: begin
        s = 16'hACE1;
        for (int i = 0; i < p; i++) s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
      end
      default: s = 16'h5A5A;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pos = 0; m_gap = 0; m_mode = 2'd0;
    m_cnt = 0; m_sum = 0; m_fsum = 0;
  endtask

  task automatic model_edge(bit en, bit f, logic [1:0] md);
    bit fe;
    logic [15:0] w;
    fe = 0;
    m_done = 0;
    if (!m_busy) begin
      if (en) begin m_busy = 1; m_pos = 0; m_mode = md; end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) fe = 1;
    end else if (!f) begin
      w = word_at(m_mode, m_pos);
      m_sum = ((m_pos == 0) ? 32'h0 : m_sum) + 32'(w);
      if (m_pos == int'(FL) - 1) begin
        m_done = 1; m_cnt++; m_fsum = m_sum; m_pos = 0;
        if (GC > 0) m_gap = int'(GC);
        else fe = 1;
      end else begin
        m_pos++;
      end
    end
    if (fe) begin
      if (en) m_mode = md;
      else m_busy = 0;
    end
  endtask

  // One clock: drive inputs, compare every output against the model, advance
  task automatic cycle(bit en, bit f, logic [1:0] md);
    bit exp_en;
    int j;
    @(negedge clk);
    enable = en; full = f; mode = md; enb = b_on;
    #1;
    exp_en = m_busy && (m_gap == 0) && !f;
    chk("wr_en", 32'(wr_en), 32'(exp_en));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(fd), 32'(m_done));
    chk("frame_cnt", 32'(fcnt), 32'(m_cnt[15:0]));
    chk("frame_start", 32'(fs), 32'(exp_en && (m_pos == 0)));
    if (m_busy && m_gap == 0) chk("data", 32'(data), 32'(word_at(m_mode, m_pos)));
`ifdef PATGEN_CHECKSUM_EN
    chk("frame_sum", fsum, m_fsum);
`endif
    if (wr_en) begin acc_q.push_back(data); acc_cyc.push_back(cyc); end
    if (b_on) begin
      if (b_k == 0) begin
        chk("b_idle_wr_en", 32'(wr_en_b), 32'h0);
      end else begin
        j = b_k - 1;
        chk("b_wr_en", 32'(wr_en_b), 32'h1);
        chk("b_data", 32'(data_b), 32'((j % 20) % 16));
        chk("b_frame_start", 32'(fs_b), 32'(j % 20 == 0));
        chk("b_frame_done", 32'(fd_b), 32'((j >= 20) && (j % 20 == 0)));
        chk("b_frame_cnt", 32'(fcnt_b), 32'(j / 20));
      end
      b_k++;
    end
    @(posedge clk);
    cyc++;
    model_edge(en, f, md);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_frame_start", 32'(fs), 32'h0);
    chk("rst_frame_done", 32'(fd), 32'h0);
    chk("rst_frame_cnt", 32'(fcnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
`ifdef PATGEN_CHECKSUM_EN
    chk("rst_frame_sum", fsum, 32'h0);
`endif
    model_reset();
    enable = 1'b0; full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    bit hit;
    model_reset();
    #7;
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_data", 32'(data), 32'h0);
    chk("init_frame_cnt", 32'(fcnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; rstb_n = 1'b1;

    // Increment frames with gap, then enable dropped at index 2
    repeat (13) cycle(1, 0, 2'd0);
    for (int k = 0; k < 8; k++) chk("inc_word", 32'(acc_q[k]), 32'(k));
    chk("inc_restart_word", 32'(acc_q[8]), 32'h0);
    chk("inc_gap_spacing", 32'(acc_cyc[8] - acc_cyc[7]), 32'd4);
    #1 chk("inc_frame_cnt", 32'(fcnt), 32'd1);
    cycle(1, 0, 2'd0);
    repeat (20) cycle(0, 0, 2'd0);
    chk("drop_words_total", 32'(acc_q.size()), 32'd16);
    chk("drop_last_word", 32'(acc_q[15]), 32'd7);
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_frame_cnt", 32'(fcnt), 32'd2);
`ifdef PATGEN_CHECKSUM_EN
    chk("sum_literal", fsum, 32'd28);
`endif

    // Full stall while data=3
    n0 = acc_q.size();
    repeat (4) cycle(1, 0, 2'd0);
    repeat (5) cycle(1, 1, 2'd0);
    repeat (20) cycle(1, 0, 2'd0);
    repeat (15) cycle(0, 0, 2'd0);
    chk("stall_word3", 32'(acc_q[n0 + 3]), 32'd3);
    chk("stall_word4", 32'(acc_q[n0 + 4]), 32'd4);
    chk("stall_spacing", 32'(acc_cyc[n0 + 3] - acc_cyc[n0 + 2]), 32'd6);

    // LFSR frames, mode wiggled mid-frame
    n0 = acc_q.size();
    repeat (13) cycle(1, 0, 2'd2);
    repeat (5) cycle(1, 0, 2'($urandom_range(0, 3)));
    repeat (25) cycle(0, 0, 2'($urandom_range(0, 3)));
    chk("lfsr_w0", 32'(acc_q[n0]), 32'hACE1);
    chk("lfsr_w1", 32'(acc_q[n0 + 1]), 32'hE270);
    chk("lfsr_w2", 32'(acc_q[n0 + 2]), 32'h7138);
    chk("lfsr_reseed", 32'(acc_q[n0 + 8]), 32'hACE1);

    // Randomized enable / full / mode
    repeat (400) cycle(($urandom % 8) != 0, ($urandom % 4) == 0, 2'($urandom % 4));
    repeat (40) cycle(0, 0, 2'd0);

    // Reset while index 4 is on the bus
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      cycle(1, 0, 2'd0);
      if (m_busy && m_gap == 0 && m_pos == 4) hit = 1;
    end
    chk("reach_index4", 32'(hit), 32'h1);
    do_reset();
    n0 = acc_q.size();
    repeat (3) cycle(1, 0, 2'd0);
    chk("post_rst_words", 32'(acc_q.size() - n0), 32'd2);
    chk("post_rst_first", 32'(acc_q[n0]), 32'h0);
    repeat (20) cycle(0, 0, 2'd0);

    // Back-to-back frames with data wrap (second instance)
    b_on = 1'b1;
    repeat (70) cycle(0, 0, 2'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
